ac_op_issuer: RTL and testbench



---
 rtl/ac_op_issuer_pkg.sv | 29 ++
 rtl/ac_op_issuer_if.sv | 38 +++
 rtl/ac_settle_timer.sv | 24 ++
 rtl/ac_op_issuer.sv | 119 +++++++++++
 tb/tb_ac_op_issuer.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ac_op_issuer_pkg.sv
// Shared types for the ALU issuer: op encodings, issuer FSM states and
// the rule for which ops return a meaningful carry.
package ac_pkg;

    localparam int AC_OP_W = 3;

    typedef enum logic [AC_OP_W-1:0] {
        AC_AND   = 3'b000,
        AC_NOT   = 3'b001,
        AC_OR    = 3'b010,
        AC_XOR   = 3'b011,
        AC_ADD   = 3'b100,
        AC_SUB   = 3'b101,
        AC_SHIFT = 3'b110,
        AC_CMP   = 3'b111
    } ac_op_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESP   = 2'd2
    } ac_issuer_state_e;

    // Only the adder path (ADD, SUB, and CMP which reuses it) drives a real carry.
    function automatic logic ac_op_uses_carry(input logic [AC_OP_W-1:0] op);
        return (op == AC_ADD) || (op == AC_SUB) || (op == AC_CMP);
    endfunction

endpackage

// File: rtl/ac_op_issuer_if.sv
// Bundle of the request, ALU-drive and response signals around the issuer.
// master = the issuer itself, slave = control unit plus ALU.
interface ac_op_issuer_if import ac_pkg::*; #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
);
    logic               req_valid;
    logic               req_ready;
    logic [AC_OP_W-1:0] req_op;
    logic [WIDTH-1:0]   req_a;
    logic [WIDTH-1:0]   req_b;

    logic [AC_OP_W-1:0] alu_op;
    logic [WIDTH-1:0]   alu_a;
    logic [WIDTH-1:0]   alu_b;
    logic [WIDTH-1:0]   alu_result;
    logic               alu_carry;

    logic               rsp_valid;
    logic               rsp_ready;
    logic [AC_OP_W-1:0] rsp_op;
    logic [WIDTH-1:0]   rsp_result;
    logic               rsp_carry;
    logic               rsp_zero;
    logic [CNT_W-1:0]   op_count;

    modport master (
        input  req_valid, req_op, req_a, req_b, alu_result, alu_carry, rsp_ready,
        output req_ready, alu_op, alu_a, alu_b,
        output rsp_valid, rsp_op, rsp_result, rsp_carry, rsp_zero, op_count
    );

    modport slave (
        output req_valid, req_op, req_a, req_b, alu_result, alu_carry, rsp_ready,
        input  req_ready, alu_op, alu_a, alu_b,
        input  rsp_valid, rsp_op, rsp_result, rsp_carry, rsp_zero, op_count
    );
endinterface

// File: rtl/ac_settle_timer.sv
// Loadable 4-bit down-counter that stops at zero; done flags the zero state.
module ac_settle_timer (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] load_value,
    output logic [3:0] count,
    output logic       done
);
    logic [3:0] count_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg <= 4'd0;
        end else if (load) begin
            count_reg <= load_value;
        end else if (count_reg != 4'd0) begin
            count_reg <= count_reg - 4'd1;
        end
    end

    assign count = count_reg;
    assign done  = (count_reg == 4'd0);
endmodule

// File: rtl/ac_op_issuer.sv
// ALU initiator: latches a request onto stable ALU lines, waits for the
// combinational ALU to settle, captures result/flags and hands them back.
module ac_op_issuer import ac_pkg::*; #(
    parameter int WIDTH         = 8,
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W         = 16
) (
    input  logic          clk,
    input  logic          reset,
    ac_op_issuer_if.master bus
);
    generate
        if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
            $error("ac_op_issuer: SETTLE_CYCLES must be in 1..15");
        end
    endgenerate

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    ac_issuer_state_e   state_reg, state_next;
    logic               req_ready;
    logic               accept;
    logic               capture;
    logic [3:0]         timer_count;
    logic               timer_done;

    logic [AC_OP_W-1:0] alu_op_reg;
    logic [WIDTH-1:0]   alu_a_reg;
    logic [WIDTH-1:0]   alu_b_reg;
    logic [AC_OP_W-1:0] rsp_op_reg;
    logic [WIDTH-1:0]   rsp_result_reg;
    logic               rsp_carry_reg;
    logic               rsp_zero_reg;
    logic [CNT_W-1:0]   op_count_reg;
    logic               rsp_valid;

    ac_settle_timer u_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (accept),
        .load_value (SETTLE_LOAD),
        .count      (timer_count),
        .done       (timer_done)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // req_ready combinationally follows rsp_ready in RESP so a retiring
    // response and a new request can share one edge.
    always_comb begin
        state_next = state_reg;
        req_ready  = 1'b0;
        case (state_reg)
            IDLE: begin
                req_ready = 1'b1;
                if (bus.req_valid) state_next = SETTLE;
            end
            SETTLE: begin
                if (timer_count == 4'd0) state_next = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    req_ready  = 1'b1;
                    state_next = bus.req_valid ? SETTLE : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign accept    = bus.req_valid & req_ready;
    assign capture   = (state_reg == SETTLE) & timer_done;
    assign rsp_valid = (state_reg == RESP);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_op_reg     <= '0;
            alu_a_reg      <= '0;
            alu_b_reg      <= '0;
            rsp_op_reg     <= '0;
            rsp_result_reg <= '0;
            rsp_carry_reg  <= 1'b0;
            rsp_zero_reg   <= 1'b0;
            op_count_reg   <= '0;
        end else begin
            if (accept) begin
                alu_op_reg <= bus.req_op;
                alu_a_reg  <= bus.req_a;
                alu_b_reg  <= bus.req_b;
            end
            if (capture) begin
                rsp_op_reg     <= alu_op_reg;
                rsp_result_reg <= bus.alu_result;
                rsp_carry_reg  <= ac_op_uses_carry(alu_op_reg) & bus.alu_carry;
                rsp_zero_reg   <= (bus.alu_result == '0);
            end
            if (rsp_valid && bus.rsp_ready && (op_count_reg != '1)) begin
                op_count_reg <= op_count_reg + 1'b1;
            end
        end
    end

    assign bus.req_ready  = req_ready;
    assign bus.alu_op     = alu_op_reg;
    assign bus.alu_a      = alu_a_reg;
    assign bus.alu_b      = alu_b_reg;
    assign bus.rsp_valid  = rsp_valid;
    assign bus.rsp_op     = rsp_op_reg;
    assign bus.rsp_result = rsp_result_reg;
    assign bus.rsp_carry  = rsp_carry_reg;
    assign bus.rsp_zero   = rsp_zero_reg;
    assign bus.op_count   = op_count_reg;
endmodule

// File: tb/tb_ac_op_issuer.sv
// Directed bench for ac_op_issuer: default instance (4 settle cycles) plus a
// 1-settle-cycle, 3-bit-counter instance for latency and saturation corners.
module tb_ac_op_issuer;
    import ac_pkg::*;

    logic clk;
    logic reset;
    logic carry_force;
    int   n_checks;
    int   n_fail;

    ac_op_issuer_if #(.WIDTH(8), .CNT_W(16)) bus ();
    ac_op_issuer_if #(.WIDTH(8), .CNT_W(3))  bus_s1 ();

    ac_op_issuer #(.WIDTH(8), .SETTLE_CYCLES(4), .CNT_W(16)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    ac_op_issuer #(.WIDTH(8), .SETTLE_CYCLES(1), .CNT_W(3)) u_dut_s1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_s1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: CMP yields result 0 and carry = (a > b).
    function automatic logic [8:0] alu_model(input logic [2:0] op, input logic [7:0] a,
                                             input logic [7:0] b);
        case (op)
            3'b000:  return {1'b0, a & b};
            3'b001:  return {1'b0, ~a};
            3'b010:  return {1'b0, a | b};
            3'b011:  return {1'b0, a ^ b};
            3'b100:  return {1'b0, a} + {1'b0, b};
            3'b101:  return {1'b0, a} + {1'b0, ~b} + 9'd1;
            3'b110:  return {a[7], a[6:0], 1'b0};
            default: return {(a > b), 8'h00};
        endcase
    endfunction

    logic [8:0] alu_out;
    logic [8:0] alu_out_s1;

    always_comb begin
        alu_out        = alu_model(bus.alu_op, bus.alu_a, bus.alu_b);
        bus.alu_result = alu_out[7:0];
        bus.alu_carry  = alu_out[8] | carry_force;
    end

    always_comb begin
        alu_out_s1        = alu_model(bus_s1.alu_op, bus_s1.alu_a, bus_s1.alu_b);
        bus_s1.alu_result = alu_out_s1[7:0];
        bus_s1.alu_carry  = alu_out_s1[8];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present a request and return at #1 after its accept edge.
    task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_valid = 1'b1;
        #1;
        for (int i = 0; i < 20 && !bus.req_ready; i++) begin
            @(posedge clk);
            #1;
        end
        check("req_ready_wait", bus.req_ready, 1);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int edges);
        edges = 0;
        do begin
            @(posedge clk);
            #1;
            edges++;
        end while (!bus.rsp_valid && edges < 20);
    endtask

    // Full transaction with rsp_ready=1: latency, captured fields, retire, count.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [7:0] a,
                          input logic [7:0] b, input logic [7:0] exp_res,
                          input logic exp_carry, input logic exp_zero, input int exp_count);
        int edges;
        issue(op, a, b);
        wait_rsp(edges);
        check({tag, "_latency"}, edges, 4);
        check({tag, "_alu_op"}, bus.alu_op, op);
        check({tag, "_rsp_op"}, bus.rsp_op, op);
        check({tag, "_result"}, bus.rsp_result, exp_res);
        check({tag, "_carry"}, bus.rsp_carry, exp_carry);
        check({tag, "_zero"}, bus.rsp_zero, exp_zero);
        @(posedge clk);
        #1;
        check({tag, "_retired"}, bus.rsp_valid, 0);
        check({tag, "_count"}, bus.op_count, exp_count);
        $display("txn %s op=%0d a=%02h b=%02h -> result=%02h carry=%0b zero=%0b count=%0d",
                 tag, op, a, b, bus.rsp_result, bus.rsp_carry, bus.rsp_zero, bus.op_count);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int edges;
        n_checks         = 0;
        n_fail           = 0;
        carry_force      = 1'b0;
        reset            = 1'b1;
        bus.req_valid    = 1'b0;
        bus.req_op       = 3'b000;
        bus.req_a        = 8'h00;
        bus.req_b        = 8'h00;
        bus.rsp_ready    = 1'b0;
        bus_s1.req_valid = 1'b0;
        bus_s1.req_op    = 3'b000;
        bus_s1.req_a     = 8'h00;
        bus_s1.req_b     = 8'h00;
        bus_s1.rsp_ready = 1'b0;

        #22 reset = 1'b0;
        #1;
        check("rst_req_ready", bus.req_ready, 1);
        check("rst_alu_op", bus.alu_op, 0);
        check("rst_alu_a", bus.alu_a, 0);
        check("rst_alu_b", bus.alu_b, 0);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_rsp_op", bus.rsp_op, 0);
        check("rst_rsp_result", bus.rsp_result, 0);
        check("rst_rsp_carry", bus.rsp_carry, 0);
        check("rst_rsp_zero", bus.rsp_zero, 0);
        check("rst_op_count", bus.op_count, 0);
        $display("txn reset released");

        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b1;
        run_op("add", 3'b100, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1);
        run_op("sub", 3'b101, 8'h05, 8'h05, 8'h00, 1'b1, 1'b1, 2);
        carry_force = 1'b1;
        run_op("and_cf", 3'b000, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 3);
        carry_force = 1'b0;
        run_op("cmp_lt", 3'b111, 8'h03, 8'h09, 8'h00, 1'b0, 1'b1, 4);
        run_op("cmp_gt", 3'b111, 8'h09, 8'h03, 8'h00, 1'b1, 1'b1, 5);

        // Backpressure: response held while a new request waits.
        bus.rsp_ready = 1'b0;
        issue(3'b010, 8'h0F, 8'h30);
        wait_rsp(edges);
        check("bp_latency", edges, 4);
        check("bp_result", bus.rsp_result, 8'h3F);
        bus.req_op    = 3'b001;
        bus.req_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.req_a = 8'(i * 17 + 1);
            bus.req_b = 8'(i * 5);
            @(posedge clk);
            #1;
            check("bp_req_ready", bus.req_ready, 0);
            check("bp_rsp_valid", bus.rsp_valid, 1);
            check("bp_rsp_result", bus.rsp_result, 8'h3F);
            check("bp_rsp_op", bus.rsp_op, 3'b010);
            check("bp_alu_op", bus.alu_op, 3'b010);
            check("bp_alu_a", bus.alu_a, 8'h0F);
            check("bp_alu_b", bus.alu_b, 8'h30);
        end
        $display("txn backpressure held 6 cycles");
        bus.req_op    = 3'b011;
        bus.req_a     = 8'hAA;
        bus.req_b     = 8'hFF;
        bus.rsp_ready = 1'b1;
        #1;
        check("b2b_req_ready", bus.req_ready, 1);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        check("b2b_rsp_valid", bus.rsp_valid, 0);
        check("b2b_alu_op", bus.alu_op, 3'b011);
        check("b2b_alu_a", bus.alu_a, 8'hAA);
        check("b2b_alu_b", bus.alu_b, 8'hFF);
        check("b2b_count", bus.op_count, 6);
        wait_rsp(edges);
        check("b2b_latency", edges, 4);
        check("b2b_result", bus.rsp_result, 8'h55);
        check("b2b_carry", bus.rsp_carry, 0);
        check("b2b_zero", bus.rsp_zero, 0);
        @(posedge clk);
        #1;
        check("b2b_count_after", bus.op_count, 7);
        $display("txn xor back-to-back result=%02h count=%0d", bus.rsp_result, bus.op_count);

        // Asynchronous reset two edges into SETTLE drops the op.
        issue(3'b100, 8'h01, 8'h02);
        @(posedge clk);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("mid_rst_alu_op", bus.alu_op, 0);
        check("mid_rst_alu_a", bus.alu_a, 0);
        check("mid_rst_alu_b", bus.alu_b, 0);
        check("mid_rst_rsp_valid", bus.rsp_valid, 0);
        check("mid_rst_count", bus.op_count, 0);
        #2;
        reset = 1'b0;
        $display("txn reset mid-settle");
        @(posedge clk);
        #1;
        run_op("post_rst_sub", 3'b101, 8'h10, 8'h01, 8'h0F, 1'b1, 1'b0, 1);

        // SETTLE_CYCLES=1 instance: streaming back-to-back, 3-bit counter saturates at 7.
        bus_s1.req_op    = 3'b100;
        bus_s1.req_a     = 8'h20;
        bus_s1.req_b     = 8'h22;
        bus_s1.rsp_ready = 1'b1;
        bus_s1.req_valid = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk);
            #1;
            check("s1_rsp_valid", bus_s1.rsp_valid, 32'(n % 2));
            check("s1_count", bus_s1.op_count, (n / 2 > 7) ? 7 : n / 2);
            if (n % 2 == 1) check("s1_result", bus_s1.rsp_result, 8'h42);
        end
        bus_s1.req_valid = 1'b0;
        $display("txn settle1 stream count=%0d", bus_s1.op_count);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
